// File: rtl/path_stack_if.sv
// path_stack_if: groups the controller-side and mover-side signals of the
// maze-path LIFO into one bundle.
//   Controller side: push, pop, dirIn -> stack;  empStck, full, overflow, depth <- stack
//   Mover side:      run, moveAck -> stack;      move, dirOut, runDone <- stack
// Modports: master (controller/mover/testbench), slave (path_stack).
interface path_stack_if #(
  parameter int AW = 8,
  parameter int DW = 2
);
  logic          push;
  logic          pop;
  logic [DW-1:0] dirIn;
  logic          run;
  logic          moveAck;
  logic          empStck;
  logic          full;
  logic          overflow;
  logic          move;
  logic [DW-1:0] dirOut;
  logic          runDone;
  logic [AW:0]   depth;

  modport master (
    output push, pop, dirIn, run, moveAck,
    input  empStck, full, overflow, move, dirOut, runDone, depth
  );

  modport slave (
    input  push, pop, dirIn, run, moveAck,
    output empStck, full, overflow, move, dirOut, runDone, depth
  );
endinterface

// File: rtl/path_stack.sv
// path_stack: LIFO store of the committed maze-search steps. While IDLE the
// controller pushes/pops 2-bit direction codes; a run request then replays
// the stored path bottom-to-top to the mover over a move/moveAck handshake,
// followed by a one-cycle runDone pulse. Contents and sp survive a replay.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - path_stack_if slave (push/pop/dirIn/run/moveAck in;
//          empStck/full/overflow/move/dirOut/runDone/depth out)
// Optional build macro PATH_STACK_PEEK_EN: in IDLE, dirOut shows the top
// entry combinationally (0 when empty); otherwise dirOut is 0 outside replay.
module path_stack #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  path_stack_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REPLAY = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   sp_q, sp_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          move_q, move_d;
  logic          run_done_q, run_done_d;
  logic [DW-1:0] dir_out_q, dir_out_d;

  logic [DW-1:0] mem_q [DEPTH];
  logic          mem_we_s;
  logic [AW-1:0] mem_waddr_s;

  logic          empty_s;
  logic          full_s;
  logic          last_s;
  logic [AW-1:0] top_idx_s;
  logic [AW-1:0] rd_next_s;

  assign empty_s   = (sp_q == {(AW+1){1'b0}});
  assign full_s    = (sp_q == (AW+1)'(DEPTH));
  // Low AW bits of sp wrap to DEPTH-1 when sp==DEPTH, which is exactly the top.
  assign top_idx_s = sp_q[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
  assign rd_next_s = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
  assign last_s    = ({1'b0, rd_ptr_q} == (sp_q - {{AW{1'b0}}, 1'b1}));

  // Next-state, pointer and output computation for the stack and replay FSM.
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    move_d      = move_q;
    run_done_d  = 1'b0;
    dir_out_d   = dir_out_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = sp_q[AW-1:0];
    case (state_q)
      IDLE: begin
        move_d    = 1'b0;
        dir_out_d = {DW{1'b0}};
        if (bus.run) begin
          // run wins over any push/pop in the same cycle.
          if (!empty_s) begin
            state_d   = REPLAY;
            rd_ptr_d  = {AW{1'b0}};
            move_d    = 1'b1;
            dir_out_d = mem_q[{AW{1'b0}}];
          end else begin
            state_d    = FINISH;
            run_done_d = 1'b1;
          end
        end else if (bus.push && bus.pop && !empty_s) begin
          // Replace the top entry in place.
          mem_we_s    = 1'b1;
          mem_waddr_s = top_idx_s;
        end else if (bus.push) begin
          if (full_s) begin
            overflow_d = 1'b1;
          end else begin
            mem_we_s = 1'b1;
            sp_d     = sp_q + {{AW{1'b0}}, 1'b1};
          end
        end else if (bus.pop && !empty_s) begin
          sp_d = sp_q - {{AW{1'b0}}, 1'b1};
        end else begin
          sp_d = sp_q;
        end
      end
      REPLAY: begin
        if (bus.moveAck) begin
          if (last_s) begin
            state_d    = FINISH;
            move_d     = 1'b0;
            run_done_d = 1'b1;
            dir_out_d  = {DW{1'b0}};
          end else begin
            rd_ptr_d  = rd_next_s;
            dir_out_d = mem_q[rd_next_s];
          end
        end else begin
          move_d = 1'b1;
        end
      end
      FINISH: begin
        state_d   = IDLE;
        move_d    = 1'b0;
        dir_out_d = {DW{1'b0}};
      end
      default: begin
        state_d   = IDLE;
        move_d    = 1'b0;
        dir_out_d = {DW{1'b0}};
      end
    endcase
  end

  // FSM state, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sp_q       <= {(AW+1){1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      overflow_q <= 1'b0;
      move_q     <= 1'b0;
      run_done_q <= 1'b0;
      dir_out_q  <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      move_q     <= move_d;
      run_done_q <= run_done_d;
      dir_out_q  <= dir_out_d;
    end
  end

  // Path storage; contents are don't-care after reset so no reset is needed.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= bus.dirIn;
    end
  end

  assign bus.empStck  = empty_s;
  assign bus.full     = full_s;
  assign bus.overflow = overflow_q;
  assign bus.move     = move_q;
  assign bus.runDone  = run_done_q;
  assign bus.depth    = sp_q;

`ifdef PATH_STACK_PEEK_EN
  logic [DW-1:0] peek_s;
  assign peek_s     = empty_s ? {DW{1'b0}} : mem_q[top_idx_s];
  assign bus.dirOut = (state_q == IDLE) ? peek_s : dir_out_q;
`else
  assign bus.dirOut = dir_out_q;
`endif

endmodule

// File: tb/tb_path_stack.sv
// tb_path_stack: directed test of path_stack. Instance u_a uses the default
// 256-entry configuration; instance u_b uses DEPTH=4 to reach full/overflow.
module tb_path_stack;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   errors;

  path_stack_if #(.AW(8), .DW(2)) bus_a ();
  path_stack_if #(.AW(2), .DW(2)) bus_b ();

  path_stack #(.DEPTH(256), .AW(8), .DW(2)) u_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  path_stack #(.DEPTH(4),   .AW(2), .DW(2)) u_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [1:0] d);
    bus_a.push  = 1'b1;
    bus_a.dirIn = d;
    step();
    bus_a.push  = 1'b0;
  endtask

  logic [1:0] seq_ack [6];
  logic [1:0] seq_dir [6];
  logic       seq_mv  [6];

  initial begin
    checks = 0;
    errors = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.push = 1'b0; bus_a.pop = 1'b0; bus_a.dirIn = 2'd0; bus_a.run = 1'b0; bus_a.moveAck = 1'b0;
    bus_b.push = 1'b0; bus_b.pop = 1'b0; bus_b.dirIn = 2'd0; bus_b.run = 1'b0; bus_b.moveAck = 1'b0;
    step();
    step();

    // Reset state
    check_eq("rst_depth",   32'(bus_a.depth), 32'd0);
    check_eq("rst_empty",   32'(bus_a.empStck), 32'd1);
    check_eq("rst_full",    32'(bus_a.full), 32'd0);
    check_eq("rst_ovf",     32'(bus_a.overflow), 32'd0);
    check_eq("rst_move",    32'(bus_a.move), 32'd0);
    check_eq("rst_done",    32'(bus_a.runDone), 32'd0);
    check_eq("rst_dirout",  32'(bus_a.dirOut), 32'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    step();

    // Push 2,1,3
    push_a(2'd2);
    push_a(2'd1);
    push_a(2'd3);
    check_eq("push3_depth", 32'(bus_a.depth), 32'd3);
    check_eq("push3_empty", 32'(bus_a.empStck), 32'd0);
`ifdef PATH_STACK_PEEK_EN
    check_eq("push3_peek",  32'(bus_a.dirOut), 32'd3);
`endif

    // Pop three times plus one pop while empty
    bus_a.pop = 1'b1;
    step();
    check_eq("pop1_depth", 32'(bus_a.depth), 32'd2);
    step();
    check_eq("pop2_depth", 32'(bus_a.depth), 32'd1);
    step();
    check_eq("pop3_depth", 32'(bus_a.depth), 32'd0);
    check_eq("pop3_empty", 32'(bus_a.empStck), 32'd1);
    step();
    check_eq("pop4_depth", 32'(bus_a.depth), 32'd0);
    check_eq("pop4_ovf",   32'(bus_a.overflow), 32'd0);
    bus_a.pop = 1'b0;

    // run on empty stack goes straight to the runDone pulse
    bus_a.run = 1'b1;
    step();
    bus_a.run = 1'b0;
    check_eq("erun_done", 32'(bus_a.runDone), 32'd1);
    check_eq("erun_move", 32'(bus_a.move), 32'd0);
    step();
    check_eq("erun_done_end", 32'(bus_a.runDone), 32'd0);

    // Push 0,1,2,3 and replay with moveAck held high
    for (int i = 0; i < 4; i++) push_a(2'(i));
    check_eq("push4_depth", 32'(bus_a.depth), 32'd4);
    bus_a.moveAck = 1'b1;
    bus_a.run = 1'b1;
    step();
    bus_a.run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rep_move%0d", i), 32'(bus_a.move), 32'd1);
      check_eq($sformatf("rep_dir%0d", i), 32'(bus_a.dirOut), 32'(i));
      step();
    end
    check_eq("rep_fin_move", 32'(bus_a.move), 32'd0);
    check_eq("rep_fin_done", 32'(bus_a.runDone), 32'd1);
    step();
    check_eq("rep_done_end", 32'(bus_a.runDone), 32'd0);
    check_eq("rep_depth",    32'(bus_a.depth), 32'd4);
    bus_a.moveAck = 1'b0;

    // Replay with moveAck 1,0,0,1,1,1
    seq_ack = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    seq_dir = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    seq_mv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bus_a.run = 1'b1;
    step();
    bus_a.run = 1'b0;
    check_eq("tog_dir_start", 32'(bus_a.dirOut), 32'd0);
    check_eq("tog_move_start", 32'(bus_a.move), 32'd1);
    for (int k = 0; k < 6; k++) begin
      bus_a.moveAck = seq_ack[k][0];
      step();
      check_eq($sformatf("tog_move%0d", k), 32'(bus_a.move), 32'(seq_mv[k]));
      if (k < 5) check_eq($sformatf("tog_dir%0d", k), 32'(bus_a.dirOut), 32'(seq_dir[k]));
      else       check_eq("tog_done", 32'(bus_a.runDone), 32'd1);
    end
    bus_a.moveAck = 1'b0;
    step();

    // Simultaneous push+pop with sp=2 replaces the top
    bus_a.pop = 1'b1;
    step();
    step();
    bus_a.pop = 1'b0;
    check_eq("pp_pre_depth", 32'(bus_a.depth), 32'd2);
    bus_a.push = 1'b1; bus_a.pop = 1'b1; bus_a.dirIn = 2'd3;
    step();
    bus_a.push = 1'b0; bus_a.pop = 1'b0;
    check_eq("pp_depth", 32'(bus_a.depth), 32'd2);
`ifdef PATH_STACK_PEEK_EN
    check_eq("pp_peek", 32'(bus_a.dirOut), 32'd3);
`endif
    bus_a.moveAck = 1'b1;
    bus_a.run = 1'b1;
    step();
    bus_a.run = 1'b0;
    check_eq("pp_rep0", 32'(bus_a.dirOut), 32'd0);
    step();
    check_eq("pp_rep1", 32'(bus_a.dirOut), 32'd3);
    step();
    check_eq("pp_rep_done", 32'(bus_a.runDone), 32'd1);
    step();
    bus_a.moveAck = 1'b0;

    // Reset asserted in the middle of a replay
    bus_a.run = 1'b1;
    step();
    bus_a.run = 1'b0;
    check_eq("mid_move_pre", 32'(bus_a.move), 32'd1);
    #2;
    rst_a = 1'b0;
    #1;
    check_eq("mid_move_rst",  32'(bus_a.move), 32'd0);
    check_eq("mid_done_rst",  32'(bus_a.runDone), 32'd0);
    check_eq("mid_depth_rst", 32'(bus_a.depth), 32'd0);
    step();
    rst_a = 1'b1;
    step();
    check_eq("mid_move_idle", 32'(bus_a.move), 32'd0);
    check_eq("mid_depth_idle", 32'(bus_a.depth), 32'd0);

    // DEPTH=4 instance: full and sticky overflow
    for (int i = 0; i < 5; i++) begin
      bus_b.push  = 1'b1;
      bus_b.dirIn = 2'(i);
      step();
      if (i == 2) check_eq("b_full3", 32'(bus_b.full), 32'd0);
      if (i == 3) begin
        check_eq("b_full4",  32'(bus_b.full), 32'd1);
        check_eq("b_ovf4",   32'(bus_b.overflow), 32'd0);
      end
    end
    bus_b.push = 1'b0;
    check_eq("b_depth5", 32'(bus_b.depth), 32'd4);
    check_eq("b_ovf5",   32'(bus_b.overflow), 32'd1);
    step();
    check_eq("b_ovf_sticky", 32'(bus_b.overflow), 32'd1);
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    check_eq("b_rst_depth", 32'(bus_b.depth), 32'd0);
    check_eq("b_rst_ovf",   32'(bus_b.overflow), 32'd0);
    check_eq("b_rst_full",  32'(bus_b.full), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/path_stack.md
Name: path_stack

Overview:
- LIFO path store for the maze solver, directly downstream of the search controller.
- Consumes the controller's push/pop strobes and the 2-bit direction of each committed step, and returns the empty flag to the controller.
- After the solve finishes, a run request replays the stored path bottom-to-top (start to destination) to the mover through a valid/ack handshake.
- Contents are held in an internal register array.

Parameters:
- DEPTH, 256, number of path entries; must be a power of two.
- AW, 8, pointer width; equals log2(DEPTH).
- DW, 2, width of a stored direction code.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; 0 resets the block.
- push  input  1  store dirIn on top of stack (one entry per cycle).
- pop  input  1  discard top entry.
- dirIn  input  DW  direction code of the committed step.
- run  input  1  start replay; sampled in IDLE only.
- moveAck  input  1  mover accepted current dirOut.
- empStck  output  1  stack holds zero entries (combinational from sp).
- full  output  1  stack holds DEPTH entries.
- overflow  output  1  sticky; a push arrived while full.
- move  output  1  dirOut valid during replay.
- dirOut  output  DW  replay direction (see Optional Feature for IDLE use).
- runDone  output  1  one-cycle pulse at end of replay.
- depth  output  AW+1  current entry count sp.

Behaviour:
- Reset (rst=0, async): state=IDLE, sp=0, rdPtr=0, overflow=0, move=0, runDone=0, dirOut=0. Array contents are don't-care.
- States: IDLE, REPLAY, FINISH.
- IDLE, push only, not full: mem[sp]<=dirIn, sp<=sp+1.
- IDLE, push only, full: write ignored, sp unchanged, overflow<=1.
- IDLE, pop only, not empty: sp<=sp-1. Data is not cleared.
- IDLE, pop only, empty: ignored, no flag raised.
- IDLE, push and pop together, not empty: mem[sp-1]<=dirIn, sp unchanged (top replaced).
- IDLE, push and pop together, empty: treated as push only.
- IDLE, run=1, sp>0: rdPtr<=0, go to REPLAY. run has priority over push/pop in the same cycle; push/pop are dropped.
- IDLE, run=1, sp=0: go to FINISH.
- REPLAY: move=1 and dirOut=mem[rdPtr], valid the same cycle the state is entered.
- REPLAY, moveAck=1: if rdPtr==sp-1, go to FINISH; else rdPtr<=rdPtr+1.
- REPLAY, moveAck=0: move and dirOut hold stable.
- REPLAY: push, pop and run are ignored. sp is never modified.
- FINISH: runDone=1 and move=0 for exactly one cycle, then IDLE. Stack contents and sp are retained, so replay is repeatable.
- Pointer arithmetic is unsigned. sp ranges 0..DEPTH and is AW+1 bits wide. full = (sp==DEPTH); empStck = (sp==0).
- Reset asserted mid-replay: immediate return to IDLE with sp=0; move and runDone deassert asynchronously.
- overflow clears only on reset.

Optional Feature:
- Macro: PATH_STACK_PEEK_EN.
- Defined: in IDLE, dirOut = mem[sp-1] combinationally (0 when empty). The controller can read the direction being popped in the pop cycle for backtracking.
- Undefined: dirOut=0 outside REPLAY. Replay behaviour is identical in both builds.

Test Plan:
- Reset, then push 2,1,3 on consecutive cycles -> depth=3, empStck=0. With PEEK_EN, dirOut=3.
- Pop three times, then a fourth pop -> depth 2,1,0; empStck=1 after the third pop; fourth pop leaves depth=0, overflow=0.
- Push 0,1,2,3, then pulse run, holding moveAck high -> move=1 for 4 cycles with dirOut 0,1,2,3, then runDone=1 for 1 cycle; depth stays 4.
- Same stack, moveAck toggled 1,0,0,1,1,1 -> dirOut holds during ack=0; sequence 0,1,2,3 unchanged.
- DEPTH=4: push 5 times -> full=1 after 4 pushes, fifth push ignored, overflow=1; assert rst low for 1 cycle -> depth=0, overflow=0.
- Push and pop together with sp=2, dirIn=3 -> depth stays 2, top reads 3 (via PEEK or replay). Assert rst during REPLAY -> move=0 immediately, state IDLE.
